// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
//   - rf_state_e : controller states (CLEAR runs the hardware clear, RUN is normal access)
//   - RF_WIDTH / RF_DEPTH : default data width and entry count
//   - rf_aw() : address width derived from the entry count
package regfile_pkg;

  localparam int unsigned RF_WIDTH = 16;
  localparam int unsigned RF_DEPTH = 16;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  // Address width for a given entry count; at least one bit.
  function automatic int unsigned rf_aw(input int unsigned depth);
    return (depth < 32'd2) ? 32'd1 : 32'($clog2(depth));
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port of the register file.
// Optional macro: REGFILE_BYPASS_EN (forward a same-edge legal write to this port).
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears q)
//   rd_en         : capture a new operand this edge; otherwise q holds
//   addr          : entry index for this port
//   mem           : storage array owned by the top
//   fwd_en        : a legal write is committing this edge
//   fwd_addr/data : address and data of that write
//   q             : registered operand
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned AW       = rf_aw(RF_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] mem [DEPTH],
  input  logic             fwd_en,
  input  logic [AW-1:0]    fwd_addr,
  input  logic [WIDTH-1:0] fwd_data,
  output logic [WIDTH-1:0] q
);

  logic             in_range_c;
  logic             zero_hit_c;
  logic [WIDTH-1:0] rdata_c;

  // Operand select: out-of-range and hardwired-zero reads return 0.
  always_comb begin
    in_range_c = (32'(addr) < DEPTH);
    zero_hit_c = (ZERO_REG != 0) && (addr == '0);
    rdata_c    = '0;
    if (in_range_c && !zero_hit_c) begin
      rdata_c = mem[addr];
    end
`ifdef REGFILE_BYPASS_EN
    // fwd_en already excludes dropped writes, so no range/zero recheck here.
    if (fwd_en && (fwd_addr == addr)) begin
      rdata_c = fwd_data;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_fwd;
  assign unused_fwd = ^{fwd_en, fwd_addr, fwd_data};
`endif

  // Output register with hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (rd_en) begin
      q <= rdata_c;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised two-read, one-write register file with hardware clear.
// Optional macro: REGFILE_BYPASS_EN (same-edge write-to-read forwarding).
// Ports:
//   clk, rst          : clock, synchronous active-high reset (restarts the clear)
//   reg_write         : write enable
//   write_addr        : write entry index
//   data_in           : write data
//   reg_read          : read enable for both ports
//   a_addr, b_addr    : read entry indices
//   a, b              : registered operands (1-cycle latency)
//   busy              : high during reset and the clear sequence
module regfile_param
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH    = RF_WIDTH,
  parameter  int unsigned DEPTH    = RF_DEPTH,
  parameter  int unsigned ZERO_REG = 0,
  localparam int unsigned AW       = rf_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write,
  input  logic [AW-1:0]    write_addr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             reg_read,
  input  logic [AW-1:0]    a_addr,
  input  logic [AW-1:0]    b_addr,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             busy
);

  rf_state_e        state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_legal_c;
  logic             we_c;
  logic [AW-1:0]    waddr_c;
  logic [WIDTH-1:0] wdata_c;
  logic             rd_en_c;

  // Next-state and storage write-port control.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    busy_d     = busy_q;
    we_c       = 1'b0;
    waddr_c    = write_addr;
    wdata_c    = data_in;
    rd_en_c    = 1'b0;
    wr_legal_c = reg_write && (state_q == RUN) && (32'(write_addr) < DEPTH)
                 && !((ZERO_REG != 0) && (write_addr == '0));

    unique case (state_q)
      CLEAR: begin
        // Clear walks entries 0..DEPTH-1; host accesses are ignored.
        we_c    = 1'b1;
        waddr_c = clr_cnt_q;
        wdata_c = '0;
        busy_d  = 1'b1;
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
          busy_d  = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      RUN: begin
        we_c    = wr_legal_c;
        rd_en_c = reg_read;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // Storage: single write port, no reset (the clear sequence zeroes it).
  always_ff @(posedge clk) begin
    if (!rst && we_c) begin
      mem[waddr_c] <= wdata_c;
    end
  end

  assign busy = busy_q;

  regfile_rdport #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_rd_a (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en_c),
    .addr     (a_addr),
    .mem      (mem),
    .fwd_en   (wr_legal_c),
    .fwd_addr (write_addr),
    .fwd_data (data_in),
    .q        (a)
  );

  regfile_rdport #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_rd_b (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en_c),
    .addr     (b_addr),
    .mem      (mem),
    .fwd_en   (wr_legal_c),
    .fwd_addr (write_addr),
    .fwd_data (data_in),
    .q        (b)
  );

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param: three instances (16 entries, 16 entries with
// hardwired zero, 12 entries) share one stimulus stream and are each compared
// against an array-based reference model.
module tb_regfile_param;

  localparam int NI = 3;

`ifdef REGFILE_BYPASS_EN
  localparam logic [15:0] COLL_EXP = 16'h5555;
`else
  localparam logic [15:0] COLL_EXP = 16'h00AA;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        reg_write;
  logic [3:0]  write_addr;
  logic [15:0] data_in;
  logic        reg_read;
  logic [3:0]  a_addr;
  logic [3:0]  b_addr;
  logic [15:0] a_o [NI];
  logic [15:0] b_o [NI];
  logic        busy_o [NI];

  int unsigned depth_m [NI] = '{16, 16, 12};
  bit          zero_m  [NI] = '{1'b0, 1'b1, 1'b0};

  logic [15:0] mem_m [NI][16];
  logic [15:0] exp_a [NI];
  logic [15:0] exp_b [NI];
  logic        exp_busy [NI];
  int          clr_left [NI];

  int tests_run = 0;
  int failures  = 0;

  regfile_param #(.WIDTH(16), .DEPTH(16), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .reg_write(reg_write), .write_addr(write_addr),
    .data_in(data_in), .reg_read(reg_read), .a_addr(a_addr), .b_addr(b_addr),
    .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0])
  );

  regfile_param #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .reg_write(reg_write), .write_addr(write_addr),
    .data_in(data_in), .reg_read(reg_read), .a_addr(a_addr), .b_addr(b_addr),
    .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1])
  );

  regfile_param #(.WIDTH(16), .DEPTH(12), .ZERO_REG(0)) u_dut2 (
    .clk(clk), .rst(rst), .reg_write(reg_write), .write_addr(write_addr),
    .data_in(data_in), .reg_read(reg_read), .a_addr(a_addr), .b_addr(b_addr),
    .a(a_o[2]), .b(b_o[2]), .busy(busy_o[2])
  );

  // Reference read: zero for out-of-range or hardwired-zero entries.
  function automatic logic [15:0] rd_m(input int i, input logic [3:0] x);
    if (32'(x) >= depth_m[i] || (zero_m[i] && x == 4'd0)) return 16'h0000;
    return mem_m[i][x];
  endfunction

  task automatic drive(input logic w, input logic [3:0] wa, input logic [15:0] d,
                       input logic r, input logic [3:0] aa, input logic [3:0] ba);
    reg_write  = w;
    write_addr = wa;
    data_in    = d;
    reg_read   = r;
    a_addr     = aa;
    b_addr     = ba;
  endtask

  // One clock edge: advance the reference model with the inputs seen at the edge.
  task automatic cyc();
    logic [15:0] ra, rb;
    bit          legal;
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        clr_left[i] = int'(depth_m[i]);
        exp_a[i]    = 16'h0;
        exp_b[i]    = 16'h0;
        exp_busy[i] = 1'b1;
        for (int j = 0; j < 16; j++) mem_m[i][j] = 16'h0;
      end else if (clr_left[i] > 0) begin
        clr_left[i] = clr_left[i] - 1;
        exp_busy[i] = (clr_left[i] != 0);
      end else begin
        legal = reg_write && (32'(write_addr) < depth_m[i])
                && !(zero_m[i] && write_addr == 4'd0);
        if (reg_read) begin
          ra = rd_m(i, a_addr);
          rb = rd_m(i, b_addr);
`ifdef REGFILE_BYPASS_EN
          if (legal && write_addr == a_addr) ra = data_in;
          if (legal && write_addr == b_addr) rb = data_in;
`endif
          exp_a[i] = ra;
          exp_b[i] = rb;
        end
        if (legal) mem_m[i][write_addr] = data_in;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
    cyc();
    cyc();
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if ({busy_o[i], a_o[i], b_o[i]} !== {1'b1, 16'h0, 16'h0}) begin
        failures++;
        $display("FAIL reset_state inst%0d: busy/a/b=%b/%h/%h required 1/0000/0000",
                 i, busy_o[i], a_o[i], b_o[i]);
      end
    end
    rst = 1'b0;
    // Host activity during the clear must be ignored.
    for (int k = 1; k <= 20; k++) begin
      if (k <= 11)
        drive(1'b1, 4'($urandom_range(15)), 16'($urandom), 1'b1,
              4'($urandom_range(15)), 4'($urandom_range(15)));
      else
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
      cyc();
      for (int i = 0; i < NI; i++) begin
        tests_run++;
        if ({busy_o[i], a_o[i], b_o[i]} !== {(k < int'(depth_m[i])), exp_a[i], exp_b[i]}) begin
          failures++;
          $display("FAIL clear_seq inst%0d edge%0d: busy/a/b=%b/%h/%h required %b/%h/%h",
                   i, k, busy_o[i], a_o[i], b_o[i], (k < int'(depth_m[i])), exp_a[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_reset_clear();
    drive(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 4'd0);
    cyc();
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 4'd5);
    cyc();
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if ({a_o[i], b_o[i]} !== {16'hBEEF, 16'hBEEF}) begin
        failures++;
        $display("FAIL preload inst%0d: a/b=%h/%h required beef/beef", i, a_o[i], b_o[i]);
      end
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 4'd5);
      cyc();
      for (int i = 0; i < NI; i++) begin
        tests_run++;
        if (busy_o[i] !== (k < int'(depth_m[i])) || (k < int'(depth_m[i]) && a_o[i] !== 16'h0)) begin
          failures++;
          $display("FAIL reclear inst%0d edge%0d: busy/a=%b/%h required %b/0000",
                   i, k, busy_o[i], a_o[i], (k < int'(depth_m[i])));
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if ({a_o[i], b_o[i]} !== {16'h0, 16'h0}) begin
        failures++;
        $display("FAIL cleared_5 inst%0d: a/b=%h/%h required 0000/0000", i, a_o[i], b_o[i]);
      end
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 4'd0);
    cyc();
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd3);
    cyc();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd9, 4'd1);
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < NI; i++) begin
        tests_run++;
        if ({a_o[i], b_o[i]} !== {16'h1234, 16'h1234}) begin
          failures++;
          $display("FAIL write_read%0d inst%0d: a/b=%h/%h required 1234/1234",
                   h, i, a_o[i], b_o[i]);
        end
      end
      cyc();
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 4'd7, 16'h00AA, 1'b0, 4'd0, 4'd0);
    cyc();
    drive(1'b1, 4'd7, 16'h5555, 1'b1, 4'd7, 4'd3);
    cyc();
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if ({a_o[i], b_o[i]} !== {COLL_EXP, 16'h1234}) begin
        failures++;
        $display("FAIL collision inst%0d: a/b=%h/%h required %h/1234", i, a_o[i], b_o[i], COLL_EXP);
      end
    end
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd7);
    cyc();
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if ({a_o[i], b_o[i]} !== {16'h1234, 16'h5555}) begin
        failures++;
        $display("FAIL after_collision inst%0d: a/b=%h/%h required 1234/5555", i, a_o[i], b_o[i]);
      end
    end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 4'd0);
    cyc();
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 4'd0);
    cyc();
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if (a_o[i] !== ((i == 1) ? 16'h0000 : 16'hFFFF)) begin
        failures++;
        $display("FAIL zero_reg inst%0d: a=%h required %h", i, a_o[i],
                 (i == 1) ? 16'h0000 : 16'hFFFF);
      end
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 4'd13, 16'h7777, 1'b0, 4'd0, 4'd0);
    cyc();
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd13, 4'd13);
    cyc();
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if ({a_o[i], b_o[i]} !== ((i == 2) ? 32'h0 : {16'h7777, 16'h7777})) begin
        failures++;
        $display("FAIL oor_read inst%0d: a/b=%h/%h", i, a_o[i], b_o[i]);
      end
    end
    for (int j = 0; j < 6; j++) begin
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'(2 * j), 4'(2 * j + 1));
      cyc();
      for (int i = 0; i < NI; i++) begin
        tests_run++;
        if ({a_o[i], b_o[i]} !== {exp_a[i], exp_b[i]}) begin
          failures++;
          $display("FAIL oor_scan inst%0d pair%0d: a/b=%h/%h required %h/%h",
                   i, j, a_o[i], b_o[i], exp_a[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_mid_clear();
    int fall_at [NI];
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) fall_at[i] = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      for (int i = 0; i < NI; i++)
        if (fall_at[i] < 0 && busy_o[i] === 1'b0) fall_at[i] = k;
    end
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if (fall_at[i] != int'(depth_m[i])) begin
        failures++;
        $display("FAIL mid_clear inst%0d: busy fell after edge %0d required %0d",
                 i, fall_at[i], depth_m[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] wa;
    for (int n = 0; n < 400; n++) begin
      wa = 4'($urandom_range(15));
      drive(1'($urandom_range(1)), wa, 16'($urandom), 1'($urandom_range(1)),
            ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15)),
            ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15)));
      cyc();
      for (int i = 0; i < NI; i++) begin
        tests_run++;
        if ({busy_o[i], a_o[i], b_o[i]} !== {1'b0, exp_a[i], exp_b[i]}) begin
          failures++;
          $display("FAIL random inst%0d cyc%0d: busy/a/b=%b/%h/%h required 0/%h/%h",
                   i, n, busy_o[i], a_o[i], b_o[i], exp_a[i], exp_b[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
    test_reset();
    test_reset_clear();
    test_write_read();
    test_collision();
    test_zero_reg();
    test_out_of_range();
    test_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
